// File: rtl/keypad_entry_ctrl_if.sv
// ============================================================================
// Module      : keypad_entry_ctrl_if
// Description : Encoder-side and downstream-side signal bundle for the
//               keypad entry controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4
) ();
    localparam int c_cnt_w = $clog2(DIGITS + 1);

    logic [3:0]          bcd_in;
    logic                valid_in;
    logic                enter;
    logic                clear;
    logic                code_ack;
    logic                enc_enablen;
    logic [4*DIGITS-1:0] code;
    logic [c_cnt_w-1:0]  digit_count;
    logic                key_strobe;
    logic                code_valid;
    logic                entry_error;

    modport master (
        output bcd_in, valid_in, enter, clear, code_ack,
        input  enc_enablen, code, digit_count, key_strobe, code_valid, entry_error
    );

    modport slave (
        input  bcd_in, valid_in, enter, clear, code_ack,
        output enc_enablen, code, digit_count, key_strobe, code_valid, entry_error
    );
endinterface

`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
// ============================================================================
// Module      : keypad_entry_ctrl
// Description : Debounces keypad encoder digits and assembles a BCD code that
//               is handed downstream with a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry_ctrl #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    keypad_entry_ctrl_if.slave bus
);
    localparam int c_code_w = 4 * DIGITS;
    localparam int c_cnt_w  = $clog2(DIGITS + 1);
    localparam int c_db_w   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DIGITS);
    localparam logic [c_db_w-1:0]  c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_CAPTURE  = 3'd2,
        S_RELEASE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                v_meta_q, v_s_q;
    logic [3:0]          b_meta_q, b_s_q;
    logic [3:0]          cand_q, cand_d;
    logic [c_db_w-1:0]   db_cnt_q, db_cnt_d;
    logic [c_code_w-1:0] code_q, code_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic                strobe_q, strobe_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic                enablen_q, enablen_d;

    // Encoder outputs are asynchronous to clk; only the second stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_meta_q <= 1'b0;
            v_s_q    <= 1'b0;
            b_meta_q <= 4'd0;
            b_s_q    <= 4'd0;
        end else begin
            v_meta_q <= bus.valid_in;
            v_s_q    <= v_meta_q;
            b_meta_q <= bus.bcd_in;
            b_s_q    <= b_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cand_q    <= 4'd0;
            db_cnt_q  <= '0;
            code_q    <= '0;
            count_q   <= '0;
            strobe_q  <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            enablen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            db_cnt_q  <= db_cnt_d;
            code_q    <= code_d;
            count_q   <= count_d;
            strobe_q  <= strobe_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            enablen_q <= enablen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        code_d   = code_q;
        count_d  = count_q;
        strobe_d = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (v_s_q) begin
                    cand_d   = b_s_q;
                    db_cnt_d = c_db_w'(1);
                    state_d  = (DEBOUNCE_CYCLES == 1) ? S_CAPTURE : S_DEBOUNCE;
                end else if (bus.enter) begin
                    if (count_q == c_full) begin
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (v_s_q && (b_s_q == cand_q)) begin
                    if (db_cnt_q >= c_db_last) begin
                        state_d = S_CAPTURE;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                state_d  = S_RELEASE;
                db_cnt_d = '0;
            end
            S_RELEASE: begin
                if (v_s_q) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q >= c_db_last) begin
                    state_d = S_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.code_ack) begin
                    code_d  = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Digit is committed on entry to CAPTURE so the outputs line up with it.
        if (state_d == S_CAPTURE) begin
            if (count_q < c_full) begin
                code_d      = code_q << 4;
                code_d[3:0] = cand_d;
                count_d     = count_q + 1'b1;
                strobe_d    = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end

        if (bus.clear) begin
            state_d  = S_IDLE;
            code_d   = '0;
            count_d  = '0;
            strobe_d = 1'b0;
            error_d  = 1'b0;
        end

        valid_d   = (state_d == S_DONE);
        enablen_d = (state_d == S_DONE);
    end

    assign bus.code        = code_q;
    assign bus.digit_count = count_q;
    assign bus.key_strobe  = strobe_q;
    assign bus.code_valid  = valid_q;
    assign bus.entry_error = error_q;
    assign bus.enc_enablen = enablen_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
// ============================================================================
// Module      : tb_keypad_entry_ctrl
// Description : Self-checking bench for keypad_entry_ctrl (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_entry_ctrl;
    localparam int N = 4;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks          = 0;
    int failures        = 0;
    int cyc             = 0;
    int n_strobe        = 0;
    int n_err           = 0;
    int last_strobe_cyc = -1;

    always #5 clk = ~clk;

    keypad_entry_ctrl_if #(.DIGITS(N)) bus ();

    keypad_entry_ctrl #(
        .DIGITS         (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.key_strobe === 1'b1) begin
            n_strobe        <= n_strobe + 1;
            last_strobe_cyc <= cyc;
        end
        if (bus.entry_error === 1'b1) n_err <= n_err + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: start returns the last edge before the first sampling edge.
    task automatic press(input int dig, input int len, input int gap, output int start);
        bus.bcd_in   = 4'(dig);
        bus.valid_in = 1'b1;
        start        = cyc;
        tick(len);
        bus.valid_in = 1'b0;
        bus.bcd_in   = 4'd0;
        tick(gap);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        tick(1);
    endtask

    task automatic fill_1234();
        int st;
        for (int i = 1; i <= 4; i++) press(i, 10, 10, st);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({bus.code, bus.digit_count} !== '0) begin
            failures++;
            $display("FAIL reset_code: code=%h count=%0d want 0/0", bus.code, bus.digit_count);
        end
        checks++;
        if ({bus.key_strobe, bus.code_valid, bus.entry_error, bus.enc_enablen} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: ks/cv/ee/en=%b want 0000",
                     {bus.key_strobe, bus.code_valid, bus.entry_error, bus.enc_enablen});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_digits();
        int st;
        int s0;
        s0 = n_strobe;
        for (int i = 1; i <= 4; i++) begin
            press(i, 10, 10, st);
            checks++;
            if (last_strobe_cyc !== st + D + 2 || n_strobe !== s0 + i) begin
                failures++;
                $display("FAIL digit_strobe_%0d: strobe at edge %0d count %0d, want edge %0d count %0d",
                         i, last_strobe_cyc, n_strobe - s0, st + D + 2, i);
            end
        end
        checks++;
        if (bus.code !== 16'h1234 || bus.digit_count !== 3'd4) begin
            failures++;
            $display("FAIL digits_code: code=%h count=%0d want 1234/4", bus.code, bus.digit_count);
        end
    endtask

    task automatic test_bounce();
        int s0;
        do_clear();
        s0 = n_strobe;
        bus.bcd_in = 4'd7;
        for (int i = 0; i < 3; i++) begin
            bus.valid_in = 1'b1;
            tick(2);
            bus.valid_in = 1'b0;
            tick(2);
        end
        bus.valid_in = 1'b1;
        tick(8);
        bus.valid_in = 1'b0;
        bus.bcd_in   = 4'd0;
        tick(2 * D + 4);
        checks++;
        if (n_strobe - s0 !== 1 || bus.code[3:0] !== 4'h7 || bus.digit_count !== 3'd1) begin
            failures++;
            $display("FAIL bounce: strobes=%0d code=%h count=%0d want 1/0007/1",
                     n_strobe - s0, bus.code, bus.digit_count);
        end
    endtask

    task automatic test_overflow();
        int st;
        int s0;
        int e0;
        do_clear();
        fill_1234();
        s0 = n_strobe;
        e0 = n_err;
        press(9, 10, 10, st);
        checks++;
        if (n_err - e0 !== 1 || n_strobe !== s0 || bus.code !== 16'h1234) begin
            failures++;
            $display("FAIL overflow: errs=%0d strobes=%0d code=%h want 1/0/1234",
                     n_err - e0, n_strobe - s0, bus.code);
        end
        bus.enter = 1'b1;
        tick(1);
        bus.enter = 1'b0;
        checks++;
        if (bus.code_valid !== 1'b1 || bus.enc_enablen !== 1'b1 || bus.code !== 16'h1234) begin
            failures++;
            $display("FAIL enter_full: cv=%b en=%b code=%h want 1/1/1234",
                     bus.code_valid, bus.enc_enablen, bus.code);
        end
        tick(1);
        bus.code_ack = 1'b1;
        tick(1);
        bus.code_ack = 1'b0;
        checks++;
        if (bus.code !== 16'h0 || bus.digit_count !== 3'd0 || bus.code_valid !== 1'b0 ||
            bus.enc_enablen !== 1'b0) begin
            failures++;
            $display("FAIL ack: code=%h count=%0d cv=%b en=%b want 0/0/0/0",
                     bus.code, bus.digit_count, bus.code_valid, bus.enc_enablen);
        end
    endtask

    task automatic test_premature_enter();
        int st;
        int e0;
        do_clear();
        press(5, 10, 10, st);
        press(6, 10, 10, st);
        e0 = n_err;
        bus.enter = 1'b1;
        tick(1);
        bus.enter = 1'b0;
        checks++;
        if (bus.entry_error !== 1'b1 || bus.code_valid !== 1'b0) begin
            failures++;
            $display("FAIL early_enter: ee=%b cv=%b want 1/0", bus.entry_error, bus.code_valid);
        end
        tick(1);
        checks++;
        if (bus.entry_error !== 1'b0 || n_err - e0 !== 1 || bus.digit_count !== 3'd2 ||
            bus.code !== 16'h0056) begin
            failures++;
            $display("FAIL early_enter_after: ee=%b errs=%0d count=%0d code=%h want 0/1/2/0056",
                     bus.entry_error, n_err - e0, bus.digit_count, bus.code);
        end
    endtask

    task automatic test_clear_ack();
        int s0;
        do_clear();
        fill_1234();
        bus.enter = 1'b1;
        tick(1);
        bus.enter    = 1'b0;
        bus.bcd_in   = 4'd5;
        bus.valid_in = 1'b1;
        tick(4);
        bus.clear    = 1'b1;
        bus.code_ack = 1'b1;
        tick(1);
        bus.clear    = 1'b0;
        bus.code_ack = 1'b0;
        s0 = n_strobe;
        checks++;
        if (bus.code !== 16'h0 || bus.digit_count !== 3'd0 || bus.code_valid !== 1'b0 ||
            bus.enc_enablen !== 1'b0) begin
            failures++;
            $display("FAIL clear_ack: code=%h count=%0d cv=%b en=%b want 0/0/0/0",
                     bus.code, bus.digit_count, bus.code_valid, bus.enc_enablen);
        end
        tick(D + 4);
        checks++;
        if (n_strobe - s0 !== 1 || bus.code !== 16'h0005 || bus.digit_count !== 3'd1) begin
            failures++;
            $display("FAIL held_recapture: strobes=%0d code=%h count=%0d want 1/0005/1",
                     n_strobe - s0, bus.code, bus.digit_count);
        end
        bus.valid_in = 1'b0;
        bus.bcd_in   = 4'd0;
        tick(2 * D + 4);
    endtask

    task automatic test_reset_mid();
        int st;
        int s0;
        // Mid-debounce
        do_clear();
        press(1, 10, 10, st);
        bus.bcd_in   = 4'd2;
        bus.valid_in = 1'b1;
        tick(4);
        bus.valid_in = 1'b0;
        rst_n        = 1'b0;
        #1;
        s0 = n_strobe;
        checks++;
        if (bus.code !== 16'h0 || bus.digit_count !== 3'd0 || bus.key_strobe !== 1'b0) begin
            failures++;
            $display("FAIL rst_debounce: code=%h count=%0d ks=%b want 0/0/0",
                     bus.code, bus.digit_count, bus.key_strobe);
        end
        tick(1);
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (n_strobe !== s0 || bus.digit_count !== 3'd0) begin
            failures++;
            $display("FAIL rst_debounce_after: strobes=%0d count=%0d want 0/0", n_strobe - s0, bus.digit_count);
        end
        // Mid-release
        bus.bcd_in   = 4'd3;
        bus.valid_in = 1'b1;
        tick(D + 4);
        bus.valid_in = 1'b0;
        rst_n        = 1'b0;
        #1;
        s0 = n_strobe;
        checks++;
        if (bus.code !== 16'h0 || bus.digit_count !== 3'd0 || bus.key_strobe !== 1'b0) begin
            failures++;
            $display("FAIL rst_release: code=%h count=%0d ks=%b want 0/0/0",
                     bus.code, bus.digit_count, bus.key_strobe);
        end
        tick(1);
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (n_strobe !== s0) begin
            failures++;
            $display("FAIL rst_release_after: strobes=%0d want 0", n_strobe - s0);
        end
        // In DONE
        fill_1234();
        bus.enter = 1'b1;
        tick(1);
        bus.enter = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.code_valid !== 1'b0 || bus.enc_enablen !== 1'b0 || bus.code !== 16'h0 ||
            bus.digit_count !== 3'd0) begin
            failures++;
            $display("FAIL rst_done: cv=%b en=%b code=%h count=%0d want 0/0/0/0",
                     bus.code_valid, bus.enc_enablen, bus.code, bus.digit_count);
        end
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    // Reference: a press of L clean cycles is accepted iff L >= D; accepted
    // digits are appended while fewer than N are held, otherwise flagged.
    task automatic test_random();
        logic [3:0]     q[$];
        logic [4*N-1:0] exp_code;
        int act, len, dig, gap, st, s0, e0, exp_s, exp_e;
        do_clear();
        for (int it = 0; it < 40; it++) begin
            act = $urandom_range(0, 9);
            if (act < 7) begin
                len = $urandom_range(1, 2 * D + 3);
                dig = $urandom_range(0, 9);
                gap = $urandom_range(2 * D + 3, 2 * D + 8);
                s0  = n_strobe;
                e0  = n_err;
                press(dig, len, gap, st);
                exp_s = 0;
                exp_e = 0;
                if (len >= D) begin
                    if (q.size() < N) begin
                        q.push_back(4'(dig));
                        exp_s = 1;
                    end else begin
                        exp_e = 1;
                    end
                end
                checks++;
                if (n_strobe - s0 !== exp_s || n_err - e0 !== exp_e) begin
                    failures++;
                    $display("FAIL rnd_press_%0d: strobes=%0d errs=%0d want %0d/%0d (len=%0d)",
                             it, n_strobe - s0, n_err - e0, exp_s, exp_e, len);
                end
                if (exp_s == 1) begin
                    checks++;
                    if (last_strobe_cyc !== st + D + 2) begin
                        failures++;
                        $display("FAIL rnd_latency_%0d: strobe edge %0d want %0d",
                                 it, last_strobe_cyc, st + D + 2);
                    end
                end
            end else if (act < 9) begin
                e0 = n_err;
                bus.enter = 1'b1;
                tick(1);
                bus.enter = 1'b0;
                if (q.size() == N) begin
                    checks++;
                    if (bus.code_valid !== 1'b1 || bus.enc_enablen !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_enter_%0d: cv=%b en=%b want 1/1", it, bus.code_valid, bus.enc_enablen);
                    end
                    tick($urandom_range(1, 3));
                    bus.code_ack = 1'b1;
                    tick(1);
                    bus.code_ack = 1'b0;
                    q.delete();
                end else begin
                    tick(1);
                    checks++;
                    if (n_err - e0 !== 1 || bus.code_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_early_%0d: errs=%0d cv=%b want 1/0", it, n_err - e0, bus.code_valid);
                    end
                end
            end else begin
                do_clear();
                q.delete();
            end
            exp_code = '0;
            foreach (q[i]) exp_code = {exp_code[4*N-5:0], q[i]};
            checks++;
            if (bus.code !== exp_code || int'(bus.digit_count) !== q.size() || bus.code_valid !== 1'b0) begin
                failures++;
                $display("FAIL rnd_state_%0d: code=%h count=%0d cv=%b want %h/%0d/0",
                         it, bus.code, bus.digit_count, bus.code_valid, exp_code, q.size());
            end
        end
    endtask

    initial begin
        bus.bcd_in   = 4'd0;
        bus.valid_in = 1'b0;
        bus.enter    = 1'b0;
        bus.clear    = 1'b0;
        bus.code_ack = 1'b0;
        test_reset();
        test_digits();
        test_bounce();
        test_overflow();
        test_premature_enter();
        test_clear_ack();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
